// File: rtl/sram_like_arbiter_pkg.sv
// Shared constants and types for the sram-like multi-channel arbiter.
package sram_like_arbiter_pkg;

   localparam logic [1:0] SZ_BYTE = 2'd0;
   localparam logic [1:0] SZ_HALF = 2'd1;
   localparam logic [1:0] SZ_WORD = 2'd2;

   localparam int DEF_NCH      = 2;
   localparam int DEF_MAX_OUTS = 4;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_LOCKED = 1'b1
   } arb_state_t;

   // Channel-ID width; never below 1 so a single-channel build still has a legal vector.
   function automatic int chid_w(input int nch);
      return (nch > 1) ? $clog2(nch) : 1;
   endfunction

endpackage

// File: rtl/sram_id_fifo.sv
// In-order channel-ID tracker for outstanding requests; registered head, no push when full, no pop when empty.
// Latency: one cycle from push to visibility at head; full/empty/count reflect registered state only.
module sram_id_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 1
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   push,
   input  logic [WIDTH-1:0]       push_dat,
   input  logic                   pop,
   output logic [WIDTH-1:0]       head,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);

   localparam int PW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic             push_ok;
   logic             pop_ok;

   assign full    = (count == (PW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) begin
            mem[wr_ptr] <= push_dat;
            wr_ptr      <= wr_ptr + PW'(1);
         end
         if (pop_ok) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         case ({push_ok, pop_ok})
            2'b10:   count <= count + (PW+1)'(1);
            2'b01:   count <= count - (PW+1)'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/sram_like_arbiter.sv
// Merges NCH sram-like masters onto one slave port; addr_ok/data_ok pass through combinationally (0 cycles).
// Backpressure: a stalled grant stays locked until m_addr_ok; no new request issues while MAX_OUTS are in flight.
module sram_like_arbiter
   import sram_like_arbiter_pkg::*;
#(
   parameter int NCH      = DEF_NCH,
   parameter int MAX_OUTS = DEF_MAX_OUTS,
   parameter int ARB_RR   = 0,
   parameter int AW       = 32
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [NCH-1:0]              ch_req,
   input  logic [NCH-1:0]              ch_wr,
   input  logic [2*NCH-1:0]            ch_size,
   input  logic [4*NCH-1:0]            ch_wstrb,
   input  logic [AW*NCH-1:0]           ch_addr,
   input  logic [32*NCH-1:0]           ch_wdata,
   output logic [NCH-1:0]              ch_addr_ok,
   output logic [NCH-1:0]              ch_data_ok,
   output logic [31:0]                 ch_rdata,
   output logic                        m_req,
   output logic                        m_wr,
   output logic [1:0]                  m_size,
   output logic [3:0]                  m_wstrb,
   output logic [AW-1:0]               m_addr,
   output logic [31:0]                 m_wdata,
   input  logic                        m_addr_ok,
   input  logic                        m_data_ok,
   input  logic [31:0]                 m_rdata,
   output logic [$clog2(MAX_OUTS):0]   outs_cnt,
   output logic                        err_spurious
);

   localparam int CHID_W = chid_w(NCH);

   arb_state_t        state;
   logic [CHID_W-1:0] lock_ch;
   logic [CHID_W-1:0] rr_ptr;
   logic [CHID_W-1:0] winner;
   logic [CHID_W-1:0] grant;
   logic [CHID_W-1:0] head;
   logic [2*NCH-1:0]  req_rot;
   logic              full;
   logic              empty;
   logic              push;
   logic              pop;
   int                sum;

   // Winner selection: highest index for fixed priority, first at/after rr_ptr for round-robin.
   always_comb begin
      winner  = '0;
      sum     = 0;
      req_rot = {ch_req, ch_req} >> rr_ptr;
      if (ARB_RR != 0) begin
         for (int j = NCH - 1; j >= 0; j--) begin
            if (req_rot[j]) begin
               sum = int'(rr_ptr) + j;
               if (sum >= NCH) begin
                  sum = sum - NCH;
               end
               winner = CHID_W'(sum);
            end
         end
      end else begin
         for (int k = 0; k < NCH; k++) begin
            if (ch_req[k]) begin
               winner = CHID_W'(k);
            end
         end
      end
   end

   assign grant = (state == ST_LOCKED) ? lock_ch : winner;
   assign m_req = !reset && ((state == ST_LOCKED) || (!full && (|ch_req)));
   assign push  = m_req && m_addr_ok;
   assign pop   = !reset && m_data_ok && !empty;

   always_comb begin
      m_wr       = 1'b0;
      m_size     = '0;
      m_wstrb    = '0;
      m_addr     = '0;
      m_wdata    = '0;
      ch_addr_ok = '0;
      ch_data_ok = '0;
      for (int k = 0; k < NCH; k++) begin
         if (grant == CHID_W'(k)) begin
            m_wr    = ch_wr[k];
            m_size  = ch_size[k*2 +: 2];
            m_wstrb = ch_wstrb[k*4 +: 4];
            m_addr  = ch_addr[k*AW +: AW];
            m_wdata = ch_wdata[k*32 +: 32];
         end
         ch_addr_ok[k] = push && (grant == CHID_W'(k));
         ch_data_ok[k] = pop && (head == CHID_W'(k));
      end
   end

   assign ch_rdata = m_rdata;

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= ST_IDLE;
         lock_ch      <= '0;
         rr_ptr       <= '0;
         err_spurious <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (m_req && !m_addr_ok) begin
                  state   <= ST_LOCKED;
                  lock_ch <= winner;
               end
            end
            ST_LOCKED: begin
               if (m_addr_ok) begin
                  state <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
         if (push && (ARB_RR != 0)) begin
            rr_ptr <= (grant == CHID_W'(NCH - 1)) ? '0 : grant + CHID_W'(1);
         end
         if (m_data_ok && empty) begin
            err_spurious <= 1'b1;
         end
      end
   end

   sram_id_fifo #(
      .DEPTH (MAX_OUTS),
      .WIDTH (CHID_W)
   ) u_id_fifo (
      .clk      (clk),
      .reset    (reset),
      .push     (push),
      .push_dat (grant),
      .pop      (pop),
      .head     (head),
      .full     (full),
      .empty    (empty),
      .count    (outs_cnt)
   );

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Scoreboard bench: a 2-channel fixed-priority arbiter (a_*) and a 3-channel round-robin one (b_*).
module tb_sram_like_arbiter;
   import sram_like_arbiter_pkg::*;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   logic [1:0]  a_req, a_wr, a_aok, a_dok;
   logic [3:0]  a_size;
   logic [7:0]  a_wstrb;
   logic [63:0] a_addr, a_wdata;
   logic [31:0] a_rdata, a_maddr, a_mwdata, a_mrdata;
   logic        a_mreq, a_mwr, a_maok, a_mdok, a_err;
   logic [1:0]  a_msize;
   logic [3:0]  a_mwstrb;
   logic [2:0]  a_cnt;

   logic [2:0]  b_req, b_wr, b_aok, b_dok;
   logic [5:0]  b_size;
   logic [11:0] b_wstrb;
   logic [95:0] b_addr, b_wdata;
   logic [31:0] b_rdata, b_maddr, b_mwdata, b_mrdata;
   logic        b_mreq, b_mwr, b_maok, b_mdok, b_err;
   logic [1:0]  b_msize;
   logic [3:0]  b_mwstrb;
   logic [2:0]  b_cnt;

   sram_like_arbiter #(.NCH(2), .MAX_OUTS(4), .ARB_RR(0), .AW(32)) dut_a (
      .clk(clk), .reset(reset),
      .ch_req(a_req), .ch_wr(a_wr), .ch_size(a_size), .ch_wstrb(a_wstrb),
      .ch_addr(a_addr), .ch_wdata(a_wdata),
      .ch_addr_ok(a_aok), .ch_data_ok(a_dok), .ch_rdata(a_rdata),
      .m_req(a_mreq), .m_wr(a_mwr), .m_size(a_msize), .m_wstrb(a_mwstrb),
      .m_addr(a_maddr), .m_wdata(a_mwdata),
      .m_addr_ok(a_maok), .m_data_ok(a_mdok), .m_rdata(a_mrdata),
      .outs_cnt(a_cnt), .err_spurious(a_err)
   );

   sram_like_arbiter #(.NCH(3), .MAX_OUTS(4), .ARB_RR(1), .AW(32)) dut_b (
      .clk(clk), .reset(reset),
      .ch_req(b_req), .ch_wr(b_wr), .ch_size(b_size), .ch_wstrb(b_wstrb),
      .ch_addr(b_addr), .ch_wdata(b_wdata),
      .ch_addr_ok(b_aok), .ch_data_ok(b_dok), .ch_rdata(b_rdata),
      .m_req(b_mreq), .m_wr(b_mwr), .m_size(b_msize), .m_wstrb(b_mwstrb),
      .m_addr(b_maddr), .m_wdata(b_mwdata),
      .m_addr_ok(b_maok), .m_data_ok(b_mdok), .m_rdata(b_mrdata),
      .outs_cnt(b_cnt), .err_spurious(b_err)
   );

   int checks = 0;
   int failures = 0;
   int a_q[$];
   int b_q[$];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic a_set(input int k, input logic wr, input logic [1:0] sz,
                        input logic [31:0] addr, input logic [31:0] wdata);
      a_wr[k]          = wr;
      a_size[k*2 +: 2] = sz;
      a_wstrb[k*4 +: 4] = wr ? 4'hF : 4'h0;
      a_addr[k*32 +: 32] = addr;
      a_wdata[k*32 +: 32] = wdata;
   endtask

   // Compare one response of dut_a against the oldest expected issuing channel.
   task automatic a_ret(input logic [31:0] d);
      int h;
      if (a_q.size() == 0) begin
         chk("a_dok_unexpected", a_dok, 0);
      end else begin
         h = a_q.pop_front();
         chk("a_dok", a_dok, 64'd1 << h);
         chk("a_rdata", a_rdata, d);
      end
   endtask

   task automatic a_drain(input int n, input logic [31:0] base);
      a_mdok = 1'b1;
      for (int i = 0; i < n; i++) begin
         a_mrdata = base + i;
         #1;
         a_ret(base + i);
         @(negedge clk);
      end
      a_mdok = 1'b0;
   endtask

   initial begin
      a_req = '0; a_wr = '0; a_size = '0; a_wstrb = '0; a_addr = '0; a_wdata = '0;
      a_maok = 1'b0; a_mdok = 1'b0; a_mrdata = '0;
      b_req = '0; b_wr = '0; b_size = '0; b_wstrb = '0; b_addr = '0; b_wdata = '0;
      b_maok = 1'b0; b_mdok = 1'b0; b_mrdata = '0;

      // Reset: requests and slave accept present, nothing may be issued.
      a_req = 2'b11; a_maok = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_mreq", a_mreq, 0);
      chk("rst_aok", a_aok, 0);
      chk("rst_dok", a_dok, 0);
      chk("rst_cnt", a_cnt, 0);
      chk("rst_err", a_err, 0);
      chk("rst_b_mreq", b_mreq, 0);
      @(negedge clk);
      reset = 1'b0; a_req = '0; a_maok = 1'b0;

      // Fixed priority: ch1 first, then ch0.
      @(negedge clk);
      a_set(0, 1'b0, SZ_BYTE, 32'h100, 32'h0);
      a_set(1, 1'b1, SZ_WORD, 32'h200, 32'hDEAD_BEEF);
      a_req = 2'b11; a_maok = 1'b1;
      #1;
      chk("fp_aok_first", a_aok, 2'b10);
      chk("fp_maddr_first", a_maddr, 32'h200);
      chk("fp_mwr_first", a_mwr, 1);
      chk("fp_msize_first", a_msize, SZ_WORD);
      chk("fp_mwdata_first", a_mwdata, 32'hDEAD_BEEF);
      a_q.push_back(1);
      @(negedge clk);
      a_req = 2'b01;
      #1;
      chk("fp_aok_second", a_aok, 2'b01);
      chk("fp_maddr_second", a_maddr, 32'h100);
      chk("fp_msize_second", a_msize, SZ_BYTE);
      a_q.push_back(0);
      @(negedge clk);
      a_req = '0; a_maok = 1'b0;
      #1;
      chk("fp_cnt", a_cnt, 2);
      chk("fp_mreq_idle", a_mreq, 0);
      a_drain(2, 32'h11);
      #1;
      chk("fp_cnt_drained", a_cnt, 0);

      // Stall: ch1 held for three cycles while ch0 also requests.
      @(negedge clk);
      a_set(1, 1'b0, SZ_WORD, 32'h1000, 32'h0);
      a_set(0, 1'b0, SZ_WORD, 32'h40, 32'h0);
      a_req = 2'b11; a_maok = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (i == 3) a_maok = 1'b1;
         #1;
         chk("stall_maddr", a_maddr, 32'h1000);
         chk("stall_aok", a_aok, (i == 3) ? 2'b10 : 2'b00);
         @(negedge clk);
      end
      a_q.push_back(1);
      a_req = 2'b01;
      #1;
      chk("stall_ch0_after", a_aok, 2'b01);
      chk("stall_ch0_maddr", a_maddr, 32'h40);
      a_q.push_back(0);
      @(negedge clk);

      // Lock must hold ch0 even when higher-priority ch1 arrives during the stall.
      a_req = 2'b01; a_maok = 1'b0;
      #1;
      chk("lock_maddr_start", a_maddr, 32'h40);
      @(negedge clk);
      a_req = 2'b11;
      for (int i = 0; i < 2; i++) begin
         #1;
         chk("lock_maddr_held", a_maddr, 32'h40);
         chk("lock_aok_none", a_aok, 2'b00);
         @(negedge clk);
      end
      a_maok = 1'b1;
      #1;
      chk("lock_aok_ch0", a_aok, 2'b01);
      a_q.push_back(0);
      @(negedge clk);
      a_req = 2'b10;
      #1;
      chk("lock_aok_ch1", a_aok, 2'b10);
      a_q.push_back(1);
      @(negedge clk);
      a_req = '0; a_maok = 1'b0;
      a_drain(4, 32'h30);

      // In-order return, third request accepted in the same cycle as the first response.
      a_set(0, 1'b0, SZ_HALF, 32'h500, 32'h0);
      a_set(1, 1'b0, SZ_HALF, 32'h600, 32'h0);
      a_req = 2'b01; a_maok = 1'b1;
      #1;
      chk("io_aok0", a_aok, 2'b01);
      a_q.push_back(0);
      @(negedge clk);
      a_req = 2'b10;
      #1;
      chk("io_aok1", a_aok, 2'b10);
      a_q.push_back(1);
      @(negedge clk);
      a_req = 2'b01; a_mdok = 1'b1; a_mrdata = 32'hA;
      #1;
      chk("io_aok2", a_aok, 2'b01);
      a_ret(32'hA);
      a_q.push_back(0);
      @(negedge clk);
      a_req = '0; a_maok = 1'b0; a_mrdata = 32'hB;
      #1;
      chk("io_cnt_overlap", a_cnt, 2);
      a_ret(32'hB);
      @(negedge clk);
      a_mrdata = 32'hC;
      #1;
      a_ret(32'hC);
      @(negedge clk);
      a_mdok = 1'b0;
      #1;
      chk("io_cnt_end", a_cnt, 0);

      // Full: four accepted, fifth waits; a pop does not admit a push in the same cycle.
      @(negedge clk);
      a_req = 2'b01; a_maok = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("full_fill_aok", a_aok, 2'b01);
         a_q.push_back(0);
         @(negedge clk);
      end
      #1;
      chk("full_mreq", a_mreq, 0);
      chk("full_aok", a_aok, 2'b00);
      chk("full_cnt", a_cnt, 4);
      a_mdok = 1'b1; a_mrdata = 32'h50;
      #1;
      a_ret(32'h50);
      chk("full_pop_mreq", a_mreq, 0);
      chk("full_pop_aok", a_aok, 2'b00);
      @(negedge clk);
      a_mdok = 1'b0;
      #1;
      chk("full_cnt_after_pop", a_cnt, 3);
      chk("full_push_next", a_aok, 2'b01);
      a_q.push_back(0);
      @(negedge clk);
      a_req = '0; a_maok = 1'b0;
      #1;
      chk("full_cnt_refill", a_cnt, 4);
      a_drain(4, 32'h60);
      #1;
      chk("full_cnt_end", a_cnt, 0);
      chk("full_err_clean", a_err, 0);

      // Round-robin on the 3-channel instance, slave responding every cycle after the first.
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         b_addr[k*32 +: 32] = 32'h1000 * (k + 1);
         b_size[k*2 +: 2] = SZ_WORD;
      end
      b_req = 3'b111; b_maok = 1'b1;
      for (int i = 0; i < 6; i++) begin
         int e;
         e = i % 3;
         if (i > 0) b_mdok = 1'b1;
         b_mrdata = 32'h700 + i;
         #1;
         chk("rr_aok", b_aok, 64'd1 << e);
         chk("rr_maddr", b_maddr, 32'h1000 * (e + 1));
         if (i > 0) begin
            chk("rr_dok", b_dok, 64'd1 << b_q.pop_front());
            chk("rr_rdata", b_rdata, 32'h700 + i);
         end
         b_q.push_back(e);
         @(negedge clk);
      end
      b_req = '0; b_maok = 1'b0;
      #1;
      chk("rr_dok_last", b_dok, 64'd1 << b_q.pop_front());
      @(negedge clk);
      b_mdok = 1'b0;
      #1;
      chk("rr_cnt_end", b_cnt, 0);
      chk("rr_err_clean", b_err, 0);

      // Reset with two requests in flight, then a late response.
      @(negedge clk);
      a_req = 2'b01; a_maok = 1'b1;
      @(negedge clk);
      a_req = 2'b10;
      @(negedge clk);
      a_req = '0; a_maok = 1'b0;
      #1;
      chk("mid_cnt_before", a_cnt, 2);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("mid_cnt_reset", a_cnt, 0);
      a_mdok = 1'b1; a_mrdata = 32'h77;
      #1;
      chk("mid_spurious_dok", a_dok, 0);
      @(negedge clk);
      a_mdok = 1'b0;
      #1;
      chk("mid_err_set", a_err, 1);
      chk("mid_cnt_after", a_cnt, 0);
      @(negedge clk);
      #1;
      chk("mid_err_held", a_err, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
